// File: rtl/apb_master_nslv.sv
// apb_master_nslv: bridges a valid/ready command port to NUM_SLAVES APB4 completers with a registered response.
// Optional build macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES cycles without PREADY.
module apb_master_nslv #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    // Command: accepted on a clock edge where req_valid & req_ready; rsp_valid holds until rsp_ready.
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [DATA_WIDTH/8-1:0]          req_strb,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR,
    output logic [1:0]                       o_dbg_state
);
    localparam int SEL_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int NUM_IDX = 2 ** SEL_W;

    if ((DATA_WIDTH % 8) != 0 || NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_master_nslv: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [SEL_W-1:0]        w_req_idx;
    logic [NUM_IDX-1:0]      w_valid_mask;
    logic                    w_dec_ok;
    logic [NUM_SLAVES-1:0]   w_req_onehot;
    logic                    w_sel_ready;
    logic                    w_sel_err;
    logic [DATA_WIDTH-1:0]   w_sel_rdata;
    logic                    w_tmo_hit;

    assign w_req_idx   = req_addr[ADDR_WIDTH-1 -: SEL_W];
    assign w_dec_ok    = w_valid_mask[w_req_idx];
    assign req_ready   = (r_state == IDLE) & PRESETn;
    assign o_dbg_state = r_state;

    always_comb begin
        w_valid_mask = '0;
        w_req_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_valid_mask[i] = 1'b1;
            w_req_onehot[i] = (SEL_W'(i) == w_req_idx);
        end
    end

    // PSEL is one-hot while a completer is addressed, so it doubles as the response mux select.
    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (PSEL[i]) begin
                w_sel_rdata = w_sel_rdata | PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_sel_ready = |(PREADY & PSEL);
    assign w_sel_err   = |(PSLVERR & PSEL);

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    // Fires on the last allowed ACCESS cycle; PREADY in that same cycle still takes priority.
    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= IDLE;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        PWRITE <= req_write;
                        PADDR  <= req_addr;
                        PWDATA <= req_wdata;
                        PSTRB  <= req_write ? req_strb : '0;
                        if (w_dec_ok) begin
                            PSEL    <= w_req_onehot;
                            r_state <= SETUP;
                        end else begin
                            // Unmapped completer: answer directly without touching the bus.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            r_state   <= RESP;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (w_sel_ready) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= w_sel_err;
                        rsp_rdata <= (!PWRITE && !w_sel_err) ? w_sel_rdata : '0;
                        r_state   <= RESP;
                    end else if (w_tmo_hit) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        r_state   <= RESP;
                    end else begin
`ifdef APB_TIMEOUT_EN
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_nslv.sv
// Bench for apb_master_nslv: three completers (index 3 unmapped), directed cases then random transfers.
// Expected responses and per-cycle bus phases are derived from the transfer rules in a scoreboard queue.
module tb_apb_master_nslv;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int NS = 3;
    localparam int TMO = 8;

    logic              PCLK;
    logic              PRESETn;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic [SW-1:0]     req_strb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [NS-1:0]     PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [SW-1:0]     PSTRB;
    logic [NS*DW-1:0]  PRDATA;
    logic [NS-1:0]     PREADY;
    logic [NS-1:0]     PSLVERR;
    logic [1:0]        dbg_state;

    int n_cmp = 0;
    int n_mis = 0;
    logic [DW:0] exp_q[$];

    apb_master_nslv #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .o_dbg_state(dbg_state)
    );

    // Clock and reset
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic randomize_slaves();
        for (int s = 0; s < NS; s++) begin
            PRDATA[s*DW +: DW] = $urandom;
            PREADY[s]  = 1'($urandom_range(0, 1));
            PSLVERR[s] = 1'($urandom_range(0, 1));
        end
    endtask

    // One complete transfer; entered and left on a negedge with the DUT idle.
    task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [SW-1:0] strb, input int waits, input logic serr,
                            input logic [DW-1:0] prd, input int rdly);
        int idx;
        logic dec_err;
        logic tmo;
        logic exp_err;
        logic [DW-1:0] exp_rd;
        logic [DW:0] exp;
        logic [NS-1:0] oh;
        int lat;
        idx = int'(addr[AW-1 -: 2]);
        dec_err = (idx >= NS);
        tmo = 1'b0;
`ifdef APB_TIMEOUT_EN
        tmo = !dec_err && (waits >= TMO);
`endif
        lat = dec_err ? 1 : (tmo ? 2 + TMO : 3 + waits);
        exp_err = dec_err || tmo || serr;
        exp_rd = (!wr && !exp_err) ? prd : '0;
        exp_q.push_back({exp_err, exp_rd});
        oh = '0;
        if (!dec_err) oh[idx] = 1'b1;

        chk("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_write = wr;
        req_addr = addr;
        req_wdata = wdata;
        req_strb = strb;
        @(posedge PCLK);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr = $urandom;
        req_wdata = $urandom;
        req_strb = SW'($urandom);

        for (int c = 1; c <= lat; c++) begin
            @(negedge PCLK);
            if (c < lat) begin
                chk("rsp_valid_early", 64'(rsp_valid), 64'(0));
                chk("req_ready_busy", 64'(req_ready), 64'(0));
                chk("psel", 64'(PSEL), 64'(oh));
                chk("penable", 64'(PENABLE), 64'(c >= 2));
                chk("paddr", 64'(PADDR), 64'(addr));
                chk("pwrite", 64'(PWRITE), 64'(wr));
                chk("pwdata", 64'(PWDATA), 64'(wdata));
                chk("pstrb", 64'(PSTRB), 64'(wr ? strb : '0));
            end else begin
                exp = exp_q.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(1));
                chk("rsp_err", 64'(rsp_err), 64'(exp[DW]));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(exp[DW-1:0]));
                chk("psel_resp", 64'(PSEL), 64'(0));
                chk("penable_resp", 64'(PENABLE), 64'(0));
                chk("req_ready_resp", 64'(req_ready), 64'(0));
            end
            randomize_slaves();
            if (!dec_err && c >= 2 && c < lat) begin
                PREADY[idx] = ((c - 1) == waits + 1);
                if (PREADY[idx]) begin
                    PSLVERR[idx] = serr;
                    PRDATA[idx*DW +: DW] = prd;
                end
            end
        end

        for (int k = 0; k < rdly; k++) begin
            req_valid = 1'($urandom_range(0, 1));
            @(negedge PCLK);
            chk("rsp_valid_hold", 64'(rsp_valid), 64'(1));
            chk("rsp_err_hold", 64'(rsp_err), 64'(exp[DW]));
            chk("rsp_rdata_hold", 64'(rsp_rdata), 64'(exp[DW-1:0]));
            chk("req_ready_hold", 64'(req_ready), 64'(0));
            chk("psel_hold", 64'(PSEL), 64'(0));
            randomize_slaves();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        chk("rsp_valid_done", 64'(rsp_valid), 64'(0));
        chk("req_ready_done", 64'(req_ready), 64'(1));
    endtask

    task automatic reset_mid_access();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 32'h0000_0040;
        req_wdata = 32'hCAFE_F00D;
        req_strb = 4'hF;
        PREADY = '0;
        @(posedge PCLK);
        #1;
        req_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("rst_pre_penable", 64'(PENABLE), 64'(1));
        PRESETn = 1'b0;
        #1;
        chk("rst_psel", 64'(PSEL), 64'(0));
        chk("rst_penable", 64'(PENABLE), 64'(0));
        chk("rst_pwrite", 64'(PWRITE), 64'(0));
        chk("rst_paddr", 64'(PADDR), 64'(0));
        chk("rst_pwdata", 64'(PWDATA), 64'(0));
        chk("rst_pstrb", 64'(PSTRB), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        PREADY = '1;
        for (int k = 0; k < 4; k++) begin
            @(negedge PCLK);
            chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("post_rst_req_ready", 64'(req_ready), 64'(1));
            chk("post_rst_psel", 64'(PSEL), 64'(0));
        end
    endtask

    initial begin
        PRESETn = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_strb = '0;
        rsp_ready = 1'b0;
        PRDATA = '0;
        PREADY = '0;
        PSLVERR = '0;
        repeat (3) @(negedge PCLK);
        chk("reset_psel", 64'(PSEL), 64'(0));
        chk("reset_penable", 64'(PENABLE), 64'(0));
        chk("reset_paddr", 64'(PADDR), 64'(0));
        chk("reset_pwdata", 64'(PWDATA), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("reset_rsp_err", 64'(rsp_err), 64'(0));
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Directed cases, issued back to back
        run_xfer(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, 0);
        run_xfer(1'b0, 32'h8000_0020, 32'h0, 4'h0, 3, 1'b0, 32'h1234_5678, 0);
        run_xfer(1'b0, 32'h8000_0004, 32'h0, 4'h0, 1, 1'b1, 32'hA5A5_A5A5, 0);
        run_xfer(1'b1, 32'hC000_0000, 32'h1111_2222, 4'h3, 0, 1'b0, 32'h0, 0);
        run_xfer(1'b0, 32'hC000_0100, 32'h0, 4'h0, 0, 1'b0, 32'h5555_AAAA, 2);
        run_xfer(1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, 1'b0, 32'h0BAD_CAFE, 5);
        run_xfer(1'b1, 32'h0000_0000, 32'h7777_8888, 4'h5, 2, 1'b1, 32'hFFFF_FFFF, 1);
        run_xfer(1'b1, 32'h4000_0100, 32'h0102_0304, 4'h1, 0, 1'b0, 32'h0, 0);
        run_xfer(1'b1, 32'h4000_0104, 32'h0506_0708, 4'h8, 0, 1'b0, 32'h0, 0);

        reset_mid_access();
        run_xfer(1'b0, 32'h4000_0040, 32'h0, 4'h0, 0, 1'b0, 32'h600D_D00D, 0);

`ifdef APB_TIMEOUT_EN
        run_xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, TMO, 1'b0, 32'h1357_9BDF, 0);
        run_xfer(1'b1, 32'h8000_0010, 32'h2468_ACE0, 4'hF, TMO + 3, 1'b0, 32'h0, 1);
        run_xfer(1'b0, 32'h4000_0010, 32'h0, 4'h0, TMO - 1, 1'b0, 32'h8642_0000, 0);
`endif

        // Randomized transfers across mapped and unmapped indices
        for (int t = 0; t < 80; t++) begin
            logic [AW-1:0] a;
            a = $urandom;
            a[AW-1 -: 2] = 2'($urandom_range(0, 3));
            run_xfer(1'($urandom_range(0, 1)), a, $urandom, SW'($urandom),
                     $urandom_range(0, 4), ($urandom_range(0, 3) == 0), $urandom,
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
